// File: rtl/mppt_pkg.sv
// rtl/mppt_pkg.sv - shared widths and FSM encodings for the P&O MPPT controller
// Purpose: single source for state codes and datapath widths used by the
//          controller, its register block and its ADC interface.
package mppt_pkg;

    localparam int STATE_W = 3;
    localparam int FLAG_W  = 2;
    localparam int ADC_W   = 12;
    localparam int P_W     = 24;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_SAMPLE   = 3'd2,
        ST_WAIT_ADC = 3'd3,
        ST_COMPUTE  = 3'd4,
        ST_DECIDE   = 3'd5,
        ST_UPDATE   = 3'd6
    } state_e;

    // flag bit positions
    localparam int FLAG_DIR  = 0;   // 1 = next perturbation increases duty
    localparam int FLAG_PVLD = 1;   // p_prev holds a real measurement

endpackage

// File: rtl/mppt_po_ctrl_if.sv
// rtl/mppt_po_ctrl_if.sv - ADC conversion handshake between controller and converter
// Purpose: groups the conversion request / result signals.
// Signals:
//   adc_start - one-cycle conversion request (controller -> ADC)
//   adc_valid - conversion done, adc_v/adc_i valid this cycle (ADC -> controller)
//   adc_v     - panel voltage code
//   adc_i     - panel current code
// Modports: master = controller side, slave = converter side.
interface mppt_po_ctrl_if;
    import mppt_pkg::*;

    logic             adc_start;
    logic             adc_valid;
    logic [ADC_W-1:0] adc_v;
    logic [ADC_W-1:0] adc_i;

    modport master (
        output adc_start,
        input  adc_valid,
        input  adc_v,
        input  adc_i
    );

    modport slave (
        input  adc_start,
        output adc_valid,
        output adc_v,
        output adc_i
    );

endinterface

// File: rtl/mppt_regs.sv
// rtl/mppt_regs.sv - FSM state and flag registers of the MPPT controller
// Purpose: holds state and flag, loaded from next-value inputs on the
//          falling clock edge with synchronous active-high reset.
// Ports:
//   clk, rst  - clock (falling edge active) and synchronous reset
//   state_d   - next state code
//   flag_d    - next flag value ([0]=direction, [1]=p_prev valid)
//   state_q   - registered state code
//   flag_q    - registered flag value
module mppt_regs
    import mppt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] state_d,
    input  logic [FLAG_W-1:0]  flag_d,
    output logic [STATE_W-1:0] state_q,
    output logic [FLAG_W-1:0]  flag_q
);

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            flag_q  <= 2'b01;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
        end
    end

endmodule

// File: rtl/mppt_po_ctrl.sv
// rtl/mppt_po_ctrl.sv - perturb-and-observe MPPT duty controller
// Purpose: periodically samples panel V/I, computes power, and steps the PWM
//          duty by STEP toward higher power, clamped to [DUTY_MIN, DUTY_MAX].
//          All registers update on the falling edge of clk.
// Ports:
//   clk, rst  - clock (falling edge active), synchronous active-high reset
//   enable    - tracking enable; 0 forces IDLE and holds duty/flag/p_prev
//   adc       - ADC handshake (master side)
//   duty      - PWM duty command
//   duty_upd  - one-cycle pulse when duty changes
//   flag      - [0]=direction (1=increase), [1]=p_prev valid
//   state     - current FSM state (debug)
//   adc_err   - sticky ADC timeout flag
module mppt_po_ctrl
    import mppt_pkg::*;
#(
    parameter int                 DUTY_W     = 8,
    parameter logic [DUTY_W-1:0]  DUTY_MIN   = 8'd13,
    parameter logic [DUTY_W-1:0]  DUTY_MAX   = 8'd242,
    parameter logic [DUTY_W-1:0]  DUTY_RST   = 8'd128,
    parameter logic [DUTY_W-1:0]  STEP       = 8'd2,
    parameter logic [15:0]        SETTLE_CYC = 16'd1000,
    parameter logic [15:0]        ADC_TO     = 16'd255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    mppt_po_ctrl_if.master      adc,
    output logic [DUTY_W-1:0]   duty,
    output logic                duty_upd,
    output logic [FLAG_W-1:0]   flag,
    output logic [STATE_W-1:0]  state,
    output logic                adc_err
);

    // Reset duty is forced into the legal window even if DUTY_RST is not.
    localparam logic [DUTY_W-1:0] DUTY_RST_C =
        (DUTY_RST < DUTY_MIN) ? DUTY_MIN :
        (DUTY_RST > DUTY_MAX) ? DUTY_MAX : DUTY_RST;

    logic [STATE_W-1:0] state_q, state_d;
    logic [FLAG_W-1:0]  flag_q, flag_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [ADC_W-1:0]   v_q, v_d, i_q, i_d;
    logic [P_W-1:0]     p_now_q, p_now_d, p_prev_q, p_prev_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic               adc_err_q, adc_err_d;
    logic               adc_start_q, adc_start_d;
    logic               duty_upd_q, duty_upd_d;

    logic [DUTY_W:0]    duty_up, duty_dn;
    logic [DUTY_W-1:0]  duty_next;
    logic               clamp;

    mppt_regs u_regs (
        .clk     (clk),
        .rst     (rst),
        .state_d (state_d),
        .flag_d  (flag_d),
        .state_q (state_q),
        .flag_q  (flag_q)
    );

    // Perturbed duty; one extra bit catches overflow above the top and
    // wrap-around below zero before clamping.
    always_comb begin
        duty_up   = {1'b0, duty_q} + {1'b0, STEP};
        duty_dn   = {1'b0, duty_q} - {1'b0, STEP};
        duty_next = duty_q;
        clamp     = 1'b0;
        if (flag_q[FLAG_DIR]) begin
            if (duty_up > {1'b0, DUTY_MAX}) begin
                duty_next = DUTY_MAX;
                clamp     = 1'b1;
            end else begin
                duty_next = duty_up[DUTY_W-1:0];
            end
        end else begin
            if (duty_dn[DUTY_W] || (duty_dn < {1'b0, DUTY_MIN})) begin
                duty_next = DUTY_MIN;
                clamp     = 1'b1;
            end else begin
                duty_next = duty_dn[DUTY_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        flag_d     = flag_q;
        cnt_d      = cnt_q;
        v_d        = v_q;
        i_d        = i_q;
        p_now_d    = p_now_q;
        p_prev_d   = p_prev_q;
        duty_d     = duty_q;
        adc_err_d  = adc_err_q;
        duty_upd_d = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_CYC - 16'd1;
                end
                ST_SETTLE: begin
                    if (cnt_q == 16'd0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    state_d = ST_WAIT_ADC;
                    cnt_d   = ADC_TO;
                end
                ST_WAIT_ADC: begin
                    // A result arriving on the timeout cycle is still taken.
                    if (adc.adc_valid) begin
                        v_d     = adc.adc_v;
                        i_d     = adc.adc_i;
                        state_d = ST_COMPUTE;
                    end else if (cnt_q <= 16'd1) begin
                        adc_err_d = 1'b1;
                        cnt_d     = 16'd0;
                        state_d   = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_COMPUTE: begin
                    p_now_d = {{(P_W-ADC_W){1'b0}}, v_q} * {{(P_W-ADC_W){1'b0}}, i_q};
                    state_d = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (!flag_q[FLAG_PVLD]) begin
                        flag_d[FLAG_PVLD] = 1'b1;
                    end else if (p_now_q < p_prev_q) begin
                        flag_d[FLAG_DIR] = ~flag_q[FLAG_DIR];
                    end
                    p_prev_d = p_now_q;
                    state_d  = ST_UPDATE;
                end
                ST_UPDATE: begin
                    duty_d = duty_next;
                    // Hitting a limit turns the search back into the window.
                    if (clamp) begin
                        flag_d[FLAG_DIR] = ~flag_q[FLAG_DIR];
                    end
                    duty_upd_d = (duty_next != duty_q);
                    state_d    = ST_SETTLE;
                    cnt_d      = SETTLE_CYC - 16'd1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // adc_start is high exactly while the FSM sits in SAMPLE.
    always_comb begin
        adc_start_d = (state_d == ST_SAMPLE);
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            v_q         <= '0;
            i_q         <= '0;
            p_now_q     <= '0;
            p_prev_q    <= '0;
            duty_q      <= DUTY_RST_C;
            adc_err_q   <= 1'b0;
            adc_start_q <= 1'b0;
            duty_upd_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            v_q         <= v_d;
            i_q         <= i_d;
            p_now_q     <= p_now_d;
            p_prev_q    <= p_prev_d;
            duty_q      <= duty_d;
            adc_err_q   <= adc_err_d;
            adc_start_q <= adc_start_d;
            duty_upd_q  <= duty_upd_d;
        end
    end

    assign adc.adc_start = adc_start_q;
    assign duty          = duty_q;
    assign duty_upd      = duty_upd_q;
    assign flag          = flag_q;
    assign state         = state_q;
    assign adc_err       = adc_err_q;

endmodule

// File: doc/mppt_po_ctrl.md
MPPT_PO_CTRL -- requirements
Module: mppt_po_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DUTY_W, 8, duty word width
- DUTY_MIN, 8'd13, lowest legal duty
- DUTY_MAX, 8'd242, highest legal duty
- DUTY_RST, 8'd128, duty after reset
- STEP, 8'd2, perturbation step
- SETTLE_CYC, 16'd1000, wait cycles after each duty change
- ADC_TO, 16'd255, ADC wait timeout in cycles
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all registers update on the falling edge
- rst, in, 1, synchronous active-high reset
- enable, in, 1, tracking enable
- adc_start, out, 1, one-cycle pulse that requests a V/I conversion
- adc_valid, in, 1, conversion done; adc_v and adc_i are valid this cycle
- adc_v, in, 12, panel voltage code
- adc_i, in, 12, panel current code
- duty, out, DUTY_W, PWM duty command
- duty_upd, out, 1, one-cycle pulse when duty changes
- flag, out, 2, [0]=direction (1=increase), [1]=p_prev valid
- state, out, 3, current FSM state (debug)
- adc_err, out, 1, sticky ADC timeout flag

Function
REQ-003 The FSM SHALL have states IDLE=0, SETTLE=1, SAMPLE=2, WAIT_ADC=3, COMPUTE=4, DECIDE=5, UPDATE=6; code 7 SHALL map to IDLE on the next edge.
REQ-004 IDLE: when enable=1, go to SETTLE and load the settle counter with SETTLE_CYC-1.
REQ-005 SETTLE: decrement the counter each cycle; at 0, go to SAMPLE.
REQ-006 SAMPLE: assert adc_start for exactly 1 cycle, load the timeout counter with ADC_TO, then go to WAIT_ADC.
REQ-007 WAIT_ADC: on adc_valid, capture adc_v and adc_i and go to COMPUTE. If the timeout counter reaches 0 first, set adc_err=1 and go to SAMPLE (retry). A coincident adc_valid wins over timeout.
REQ-008 COMPUTE: p_now = adc_v*adc_i, unsigned 24-bit, no truncation; go to DECIDE.
REQ-009 DECIDE, when flag[1]=0: keep direction, set flag[1]=1, go to UPDATE.
REQ-009a DECIDE, when p_now<p_prev: invert flag[0], then go to UPDATE.
REQ-009b DECIDE, when p_now>=p_prev: keep flag[0], then go to UPDATE.
REQ-009c In every DECIDE case, p_prev SHALL be set to p_now.
REQ-010 UPDATE: compute duty ± STEP in DUTY_W+1 bits and clamp to [DUTY_MIN, DUTY_MAX].
REQ-010a If clamping occurs, invert flag[0] so the next perturbation moves away from the limit.
REQ-010b If the new duty differs from the old, pulse duty_upd for 1 cycle.
REQ-010c After UPDATE, go to SETTLE.
REQ-011 enable=0 in any state SHALL force IDLE on the next edge. Duty, flag and p_prev are held; adc_start and duty_upd are 0.
REQ-012 Latency from adc_valid to duty_upd SHALL be 3 cycles (COMPUTE, DECIDE, UPDATE).
REQ-013 duty SHALL never leave [DUTY_MIN, DUTY_MAX], including at reset.

Reset
REQ-014 rst SHALL be sampled on the falling clk edge and takes priority over all other inputs.
REQ-014a Reset values: state=IDLE, duty=DUTY_RST, flag=2'b01, p_prev=0, adc_err=0, adc_start=0, duty_upd=0, all counters 0.
REQ-015 Reset asserted mid-cycle of any state SHALL abort that state; no duty_upd is issued for the aborted iteration.

Structure
REQ-016 A shared package mppt_pkg SHALL hold the state encodings, STATE_W=3, FLAG_W=2, ADC_W=12 and P_W=24.
REQ-017 One sub-module, mppt_regs, SHALL hold the state and flag registers with next-value inputs, using the same edge and reset scheme. The mppt_po_ctrl top level holds the next-state logic, the counters and the arithmetic.

Verification (SETTLE_CYC=4, ADC_TO=8 unless noted)
REQ-018 Reset release, enable=1, ADC returns 100x100, then 110x100 -> first UPDATE sets duty=130, flag=2'b11; second UPDATE sets duty=132.
REQ-019 Power drop: prev 110x100, now 100x100 -> flag[0]=0 and duty decreases by 2; duty_upd occurs 3 cycles after adc_valid.
REQ-020 Clamp: duty=241, direction up, rising power -> duty=242 and flag[0]=0; the next iteration gives 240.
REQ-021 Timeout: adc_valid never asserted -> adc_err=1 on cycle 8 of WAIT_ADC, a second adc_start follows, and duty is unchanged.
REQ-022 enable dropped during WAIT_ADC -> IDLE on the next edge, no duty_upd, duty held. Re-enable -> SETTLE lasts 4 cycles.
REQ-023 rst asserted in COMPUTE -> the next falling edge gives state=0, duty=128, flag=2'b01, and duty_upd is never asserted.
